// File: rtl/bypass_ctrl.sv
// ---------------------------------------------------------------------------
// bypass_ctrl
//   Operand-bypass and load-use hazard controller for a 5-stage pipeline.
//   It tracks destination tags of the instructions in X, M and W and
//   registers 2-bit selects for the two X-stage operand mux4s. It also
//   produces a combinational load-use stall for decode.
//
//   Select codes (per operand):
//     0 register file
//     1 M result        (producer was in X when the consumer sat in decode)
//     2 W result        (producer was in M)
//     3 retired latch   (producer was in W, only when USE_WB_BYPASS != 0)
//
// Parameters
//   REG_ADDR_W     register-index width
//   USE_WB_BYPASS  1: select 3 may be produced, 0: never produced
//
// Ports
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset
//   pipe_hold     global pipeline freeze
//   flush         squash the instruction leaving decode
//   id_valid      decode holds a real instruction
//   id_rs/id_rt   decode source indices, id_use_rs/id_use_rt qualify them
//   id_we/id_rd   decode destination write enable and index
//   id_is_load    decode instruction is a load
//   sel_a/sel_b   registered operand mux selects for the instruction in X
//   hazard_stall  load-use stall for decode (combinational)
//   stall_count   stall-cycle counter
//
// Build option
//   STALL_COUNTER_EN  when defined, stall_count counts stall edges and wraps;
//                     otherwise stall_count is tied to zero.
// ---------------------------------------------------------------------------
module bypass_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int USE_WB_BYPASS = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pipe_hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_we,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  hazard_stall,
  output logic [31:0]           stall_count
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
  } tag_t;

  tag_t       x_q, x_d;
  tag_t       m_q, m_d;
  tag_t       w_q, w_d;
  // Only the X slot needs the load flag: a load can only cause a stall while
  // it sits directly ahead of its consumer.
  logic       x_load_q, x_load_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;

  logic [1:0] sel_a_nxt;
  logic [1:0] sel_b_nxt;
  logic       haz_rs;
  logic       haz_rt;
  logic       stall;
  logic       issue;

  // Register 0 is hard-wired, so a write to it is never a producer.
  function automatic logic writes_reg(input tag_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid && e.we && (e.rd == r) && (r != '0);
  endfunction

  // Youngest producer wins: X, then M, then W.
  function automatic logic [1:0] src_sel(
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] r,
    input tag_t                  ex,
    input tag_t                  me,
    input tag_t                  wb
  );
    logic [1:0] s;
    s = 2'd0;
    if (use_src && (r != '0)) begin
      if (writes_reg(ex, r)) begin
        s = 2'd1;
      end else if (writes_reg(me, r)) begin
        s = 2'd2;
      end else if ((USE_WB_BYPASS != 0) && writes_reg(wb, r)) begin
        s = 2'd3;
      end
    end
    return s;
  endfunction

  always_comb begin
    sel_a_nxt = src_sel(id_use_rs, id_rs, x_q, m_q, w_q);
    sel_b_nxt = src_sel(id_use_rt, id_rt, x_q, m_q, w_q);
  end

  // The stall looks only at the X slot; it stays live during pipe_hold and
  // flush so decode always sees the true hazard of the current state.
  always_comb begin
    haz_rs = id_use_rs && writes_reg(x_q, id_rs);
    haz_rt = id_use_rt && writes_reg(x_q, id_rt);
    stall  = x_load_q && (haz_rs || haz_rt);
    issue  = id_valid && !stall && !flush;
  end

  assign hazard_stall = stall;

  always_comb begin
    x_d      = x_q;
    m_d      = m_q;
    w_d      = w_q;
    x_load_d = x_load_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    if (!pipe_hold) begin
      w_d      = m_q;
      m_d      = x_q;
      // Default: a bubble enters X with both selects at the register file.
      x_d      = '0;
      x_load_d = 1'b0;
      sel_a_d  = 2'd0;
      sel_b_d  = 2'd0;
      if (issue) begin
        x_d.valid = 1'b1;
        x_d.we    = id_we;
        x_d.rd    = id_rd;
        x_load_d  = id_is_load;
        sel_a_d   = sel_a_nxt;
        sel_b_d   = sel_b_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      x_load_q <= 1'b0;
      sel_a_q  <= 2'd0;
      sel_b_q  <= 2'd0;
    end else begin
      x_q      <= x_d;
      m_q      <= m_d;
      w_q      <= w_d;
      x_load_q <= x_load_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Natural 32-bit wrap from all-ones back to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !pipe_hold) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_bypass_ctrl.sv
// Bench for bypass_ctrl: directed pipeline scenarios followed by random
// traffic, all checked against an in-flight instruction list model.
module tb_bypass_ctrl;

  localparam int USE_WB = 1;

  logic        clock;
  logic        reset_n;
  logic        pipe_hold;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_we;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic        hazard_stall;
  logic [31:0] stall_count;

  bypass_ctrl #(.REG_ADDR_W(5), .USE_WB_BYPASS(USE_WB)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pipe_hold    (pipe_hold),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_we        (id_we),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .hazard_stall (hazard_stall),
    .stall_count  (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } rec_t;

  // pipe[age]: age 0 = instruction in X, 1 = in M, 2 = in W
  rec_t        pipe [3];
  logic [1:0]  exp_sel_a;
  logic [1:0]  exp_sel_b;
  logic [31:0] exp_cnt;
  logic        known;
  logic        haz_seen;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forwarding distance: the producer's age ahead of the consumer picks the
  // result stage it is read from.
  function automatic logic [1:0] model_sel(input logic use_src, input logic [4:0] r);
    if (!use_src || r == 5'd0) return 2'd0;
    for (int age = 0; age < 3; age++) begin
      if (pipe[age].valid && pipe[age].we && pipe[age].rd == r) begin
        if (age == 2 && USE_WB == 0) return 2'd0;
        return 2'(age + 1);
      end
    end
    return 2'd0;
  endfunction

  function automatic logic model_hazard(input logic urs, input logic [4:0] rs,
                                        input logic urt, input logic [4:0] rt);
    rec_t p;
    p = pipe[0];
    if (!(p.valid && p.ld && p.we && p.rd != 5'd0)) return 1'b0;
    return (urs && rs == p.rd) || (urt && rt == p.rd);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 1'b0, 5'd0, 1'b0};
    exp_sel_a = 2'd0;
    exp_sel_b = 2'd0;
    exp_cnt   = 32'd0;
  endtask

  task automatic step(input logic rn, input logic hd, input logic fl, input logic vl,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic we,
                      input logic [4:0] rd, input logic ld);
    logic haz;
    logic iss;
    reset_n    = rn;
    pipe_hold  = hd;
    flush      = fl;
    id_valid   = vl;
    id_rs      = rs;
    id_rt      = rt;
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_we      = we;
    id_rd      = rd;
    id_is_load = ld;
    #1;
    haz      = model_hazard(urs, rs, urt, rt);
    haz_seen = hazard_stall;
    if (known) check("hazard_stall", {31'd0, hazard_stall}, {31'd0, haz});
    if (!rn) begin
      clear_model();
      known = 1'b1;
    end else if (!hd) begin
`ifdef STALL_COUNTER_EN
      if (haz) exp_cnt = exp_cnt + 32'd1;
`endif
      iss       = vl && !haz && !fl;
      exp_sel_a = iss ? model_sel(urs, rs) : 2'd0;
      exp_sel_b = iss ? model_sel(urt, rt) : 2'd0;
      pipe[2]   = pipe[1];
      pipe[1]   = pipe[0];
      if (iss) pipe[0] = '{1'b1, we, rd, ld};
      else     pipe[0] = '{1'b0, 1'b0, 5'd0, 1'b0};
    end
    @(posedge clock);
    #1;
    check("sel_a", {30'd0, sel_a}, {30'd0, exp_sel_a});
    check("sel_b", {30'd0, sel_b}, {30'd0, exp_sel_b});
    check("stall_count", stall_count, exp_cnt);
  endtask

  // Normal issue of "rd <- op(rs, rt)", both sources read.
  task automatic ins(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ld);
    step(1'b1, 1'b0, 1'b0, 1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, ld);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    known    = 1'b0;
    clear_model();

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_sel_a", {30'd0, sel_a}, 32'd0);
    check("rst_count", stall_count, 32'd0);

    // Back-to-back dependency on r3
    ins(5'd3, 5'd1, 5'd2, 1'b0);
    ins(5'd4, 5'd3, 5'd5, 1'b0);
    check("t1_sel_a", {30'd0, sel_a}, 32'd1);
    check("t1_sel_b", {30'd0, sel_b}, 32'd0);

    // r7 consumed as rt after one and two independents
    ins(5'd7, 5'd1, 5'd1, 1'b0);
    ins(5'd8, 5'd1, 5'd1, 1'b0);
    ins(5'd10, 5'd1, 5'd7, 1'b0);
    check("t2_sel_b_m", {30'd0, sel_b}, 32'd2);
    check("t2_sel_a_rf", {30'd0, sel_a}, 32'd0);
    ins(5'd7, 5'd1, 5'd1, 1'b0);
    ins(5'd8, 5'd1, 5'd1, 1'b0);
    ins(5'd8, 5'd1, 5'd1, 1'b0);
    ins(5'd10, 5'd1, 5'd7, 1'b0);
    check("t2_sel_b_w", {30'd0, sel_b}, (USE_WB != 0) ? 32'd3 : 32'd0);

    // Load-use on r2
    ins(5'd2, 5'd1, 5'd1, 1'b1);
    ins(5'd6, 5'd2, 5'd2, 1'b0);
    check("t3_stall", {31'd0, haz_seen}, 32'd1);
    check("t3_bubble_sel", {30'd0, sel_a}, 32'd0);
    ins(5'd6, 5'd2, 5'd2, 1'b0);
    check("t3_nostall", {31'd0, haz_seen}, 32'd0);
    check("t3_sel_a", {30'd0, sel_a}, 32'd2);
    check("t3_sel_b", {30'd0, sel_b}, 32'd2);

    // r0 is never forwarded nor stalled on; youngest producer wins for r9
    ins(5'd0, 5'd1, 5'd1, 1'b0);
    ins(5'd11, 5'd0, 5'd0, 1'b0);
    check("t4_r0_sel", {30'd0, sel_a}, 32'd0);
    ins(5'd0, 5'd1, 5'd1, 1'b1);
    ins(5'd11, 5'd0, 5'd0, 1'b0);
    check("t4_r0_nostall", {31'd0, haz_seen}, 32'd0);
    ins(5'd9, 5'd1, 5'd1, 1'b0);
    ins(5'd9, 5'd1, 5'd1, 1'b0);
    ins(5'd12, 5'd9, 5'd9, 1'b0);
    check("t4_young_a", {30'd0, sel_a}, 32'd1);
    check("t4_young_b", {30'd0, sel_b}, 32'd1);

    // Load-use stall frozen by pipe_hold, then released
    ins(5'd11, 5'd1, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 5'd11, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0);
      check("t5_hold_stall", {31'd0, haz_seen}, 32'd1);
    end
    ins(5'd14, 5'd11, 5'd11, 1'b0);
    check("t5_rel_stall", {31'd0, haz_seen}, 32'd1);
    ins(5'd14, 5'd11, 5'd11, 1'b0);
    check("t5_after_sel", {30'd0, sel_a}, 32'd2);

    // Flush on the stall cycle
    ins(5'd12, 5'd1, 5'd1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0);
    check("t5_flush_sel", {30'd0, sel_b}, 32'd0);
    ins(5'd13, 5'd12, 5'd12, 1'b0);
    check("t5_flush_clear", {31'd0, haz_seen}, 32'd0);

    // Reset in the middle of a stall
    ins(5'd13, 5'd1, 5'd1, 1'b1);
    ins(5'd14, 5'd13, 5'd13, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 5'd13, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0);
    check("t6_rst_count", stall_count, 32'd0);
    ins(5'd14, 5'd13, 5'd13, 1'b0);
    check("t6_reissue_stall", {31'd0, haz_seen}, 32'd0);
    check("t6_reissue_sel", {30'd0, sel_a}, 32'd0);

    // Random traffic on a small register window to provoke collisions
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 8,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
